// File: rtl/rng_pkg.sv
// Shared types and default constants for the random word pool.
package rng_pkg;

  typedef enum logic [1:0] {
    WARM = 2'd0,
    RUN  = 2'd1,
    FAIL = 2'd2
  } rng_state_e;

  localparam logic [63:0] DEF_TAPS = 64'hD800_0000_0000_0000;
  localparam logic [63:0] DEF_INIT = '1;
  localparam int unsigned WCNT_W   = 8;

endpackage

// File: rtl/rng_lane.sv
// Single Galois LFSR lane: steps every cycle unless loaded or in reset.
module rng_lane import rng_pkg::*; #(
  parameter int unsigned    W         = 64,
  parameter logic [W-1:0]   TAPS      = W'(DEF_TAPS),
  parameter logic [W-1:0]   RESET_VAL = '1
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_data,
  output logic [W-1:0] state
);

  always_ff @(posedge clock) begin
    if (!reset_n)  state <= RESET_VAL;
    else if (load) state <= load_data;
    else           state <= (state >> 1) ^ (state[0] ? TAPS : '0);
  end

endmodule

// File: rtl/rng_pool.sv
// Pool of XOR-combined LFSR lanes feeding a show-ahead FIFO, with warmup
// discard and a sticky repetition health test.
module rng_pool import rng_pkg::*; #(
  parameter int unsigned      DBITS     = 64,
  parameter int unsigned      LANES     = 2,
  parameter int unsigned      DEPTH     = 4,
  parameter logic [DBITS-1:0] TAPS      = DBITS'(DEF_TAPS),
  parameter logic [DBITS-1:0] INIT      = '1,
  parameter int unsigned      WARMUP    = 16,
  parameter int unsigned      REP_LIMIT = 3
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       seed_en,
  input  logic [DBITS-1:0]           seed_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DBITS-1:0]           out_data,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       health_fail
);

  localparam int unsigned LW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned RW = $clog2(REP_LIMIT + 1);

  logic [DBITS-1:0]  lane_q [LANES];
  logic [DBITS-1:0]  w_c;
  rng_state_e        state_q, state_nxt;
  logic [WCNT_W-1:0] warm_q;
  logic [RW-1:0]     rep_q, rep_nxt_c;
  logic [DBITS-1:0]  prev_q;
  logic              run_c, trip_c, pop_c, push_c, flush_c;
  logic [DBITS-1:0]  mem_q [DEPTH];
  logic [PW-1:0]     rd_q, wr_q;
  logic [LW-1:0]     cnt_q, cnt_nxt_c;

  // Lane i seeds from seed_data rotated left by i; a zero result falls back to INIT^i.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    localparam logic [DBITS-1:0] LANE_INIT = INIT ^ DBITS'(i);
    logic [DBITS-1:0] rot_c, load_c;
    assign rot_c  = (seed_data << i) | (seed_data >> (DBITS - i));
    assign load_c = (rot_c == '0) ? LANE_INIT : rot_c;
    rng_lane #(
      .W         (DBITS),
      .TAPS      (TAPS),
      .RESET_VAL (LANE_INIT)
    ) u_lane (
      .clock     (clock),
      .reset_n   (reset_n),
      .load      (seed_en),
      .load_data (load_c),
      .state     (lane_q[i])
    );
  end

  always_comb begin
    w_c = '0;
    for (int unsigned i = 0; i < LANES; i++) w_c = w_c ^ lane_q[i];
  end

  // The last warmup step doubles as the first RUN cycle, so WARMUP=0 runs immediately.
  always_comb begin
    run_c     = (state_q == RUN) || ((state_q == WARM) && (warm_q == WCNT_W'(WARMUP)));
    rep_nxt_c = ((rep_q != '0) && (w_c == prev_q)) ? rep_q + RW'(1) : RW'(1);
    trip_c    = run_c && (rep_nxt_c >= RW'(REP_LIMIT));
  end

  always_ff @(posedge clock) begin
    if (!reset_n) state_q <= WARM;
    else          state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    if (seed_en) begin
      state_nxt = WARM;
    end else begin
      case (state_q)
        WARM:    if (trip_c) state_nxt = FAIL; else if (run_c) state_nxt = RUN;
        RUN:     if (trip_c) state_nxt = FAIL;
        default: state_nxt = state_q;
      endcase
    end
  end

  // Seeding and a health trip both flush; neither lets a pop or push through.
  always_comb begin
    flush_c = seed_en || trip_c;
    pop_c   = out_valid && out_ready && !flush_c;
    push_c  = run_c && !flush_c && ((cnt_q != LW'(DEPTH)) || pop_c);
  end

  always_ff @(posedge clock) begin
    if (!reset_n || seed_en) begin
      warm_q      <= '0;
      rep_q       <= '0;
      prev_q      <= '0;
      health_fail <= 1'b0;
    end else begin
      if ((state_q == WARM) && !run_c) warm_q <= warm_q + WCNT_W'(1);
      if (run_c) begin
        rep_q  <= rep_nxt_c;
        prev_q <= w_c;
      end
      if (trip_c) health_fail <= 1'b1;
    end
  end

  always_comb begin
    cnt_nxt_c = cnt_q;
    if (flush_c)              cnt_nxt_c = '0;
    else if (push_c && !pop_c) cnt_nxt_c = cnt_q + LW'(1);
    else if (pop_c && !push_c) cnt_nxt_c = cnt_q - LW'(1);
  end

  always_ff @(posedge clock) begin
    if (!reset_n || flush_c) begin
      rd_q      <= '0;
      wr_q      <= '0;
      cnt_q     <= '0;
      out_valid <= 1'b0;
    end else begin
      if (pop_c)  rd_q <= rd_q + PW'(1);
      if (push_c) wr_q <= wr_q + PW'(1);
      cnt_q     <= cnt_nxt_c;
      out_valid <= (cnt_nxt_c != '0);
    end
  end

  always_ff @(posedge clock) begin
    if (push_c) mem_q[wr_q] <= w_c;
  end

  assign out_data = mem_q[rd_q];
  assign level    = cnt_q;

endmodule
